// File: rtl/key_step_gen.sv
// Debounced 4-button step-strobe generator with optional auto-repeat.
// Auto-repeat is enabled by defining KEY_STEP_AUTO_REPEAT_EN.
module key_step_gen #(
  parameter int unsigned DB_CYCLES     = 500000,
  parameter int unsigned REPEAT_DELAY  = 25000000,
  parameter int unsigned REPEAT_PERIOD = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn_raw,
  output logic [3:0] keys,
  output logic [3:0] held
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StFirst  = 2'd1,
    StRepeat = 2'd2
  } state_e;

  localparam logic [19:0] DbMax   = 20'(DB_CYCLES);
  localparam logic [25:0] DelayM1 = 26'(REPEAT_DELAY - 1);
`ifdef KEY_STEP_AUTO_REPEAT_EN
  localparam logic [25:0] PeriodM1 = 26'(REPEAT_PERIOD - 1);
`endif

  logic [3:0]       sync1_q, sync2_q;
  logic [3:0]       held_q, held_d;
  logic [3:0][19:0] db_cnt_q, db_cnt_d;
  logic [3:0]       keys_q, keys_d;
  logic [3:0]       last_q, last_d;
  logic [25:0]      rcnt_q, rcnt_d;
  state_e           state_q, state_d;
  logic [3:0]       sel;

  // Counter only runs while the synchronized level disagrees with the accepted level.
  always_comb begin
    held_d   = held_q;
    db_cnt_d = db_cnt_q;
    for (int i = 0; i < 4; i++) begin
      if (sync2_q[i] == held_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DbMax) begin
        db_cnt_d[i] = '0;
        held_d[i]   = ~held_q[i];
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + 20'd1;
      end
    end
  end

  always_comb begin
    sel = 4'b0000;
    if (held_q[3])      sel = 4'b1000;
    else if (held_q[2]) sel = 4'b0100;
    else if (held_q[1]) sel = 4'b0010;
    else if (held_q[0]) sel = 4'b0001;
  end

  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    last_d  = last_q;
    keys_d  = 4'b0000;
    case (state_q)
      StIdle: begin
        if (sel != 4'b0000) begin
          keys_d  = sel;
          last_d  = sel;
          rcnt_d  = DelayM1;
          state_d = StFirst;
        end
      end
      StFirst, StRepeat: begin
        if (sel == 4'b0000) begin
          state_d = StIdle;
        end else if (sel != last_q) begin
          keys_d  = sel;
          last_d  = sel;
          rcnt_d  = DelayM1;
          state_d = StFirst;
        end
`ifdef KEY_STEP_AUTO_REPEAT_EN
        else if (rcnt_q == 26'd0) begin
          keys_d  = last_q;
          rcnt_d  = PeriodM1;
          state_d = StRepeat;
        end else begin
          rcnt_d = rcnt_q - 26'd1;
        end
`endif
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

`ifndef KEY_STEP_AUTO_REPEAT_EN
  logic unused_repeat;
  assign unused_repeat = ^{REPEAT_PERIOD, rcnt_q};
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      held_q   <= '0;
      db_cnt_q <= '0;
      keys_q   <= '0;
      last_q   <= '0;
      rcnt_q   <= '0;
      state_q  <= StIdle;
    end else begin
      sync1_q  <= btn_raw;
      sync2_q  <= sync1_q;
      held_q   <= held_d;
      db_cnt_q <= db_cnt_d;
      keys_q   <= keys_d;
      last_q   <= last_d;
      rcnt_q   <= rcnt_d;
      state_q  <= state_d;
    end
  end

  assign keys = keys_q;
  assign held = held_q;

endmodule
